status_unit: RTL and testbench
==============================

# status_unit

Parametrised successor of the CPU status register: holds the architectural flag word and updates it from the ALU under a per-bit write mask. Adds software load/xor/set/clear writes (the LSTAT/XSTAT instructions), sticky flags, and a save/restore stack for nested traps and calls. Provides a trap request/acknowledge handshake to the control sequencer. Sits between the ALU/memory units and the CPU control FSM.

## Interface
Parameters:
- FLAG_W, 16: flag word width; must be ≥13.
- STACK_DEPTH, 4: save-stack entries; must be ≥1.
- STICKY_MASK, 16'h0C8C: bits that ALU updates can only set, never clear. Default covers O, U, DZ, MV, MC.
- TRAP_MASK, 16'h0C80: bits whose assertion raises a trap. Default covers DZ, MV, MC.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- alu_we  in  FLAG_W  per-bit update enable from ALU
- alu_flags  in  FLAG_W  ALU flag results
- sw_we  in  1  software write strobe
- sw_op  in  2  0=load, 1=xor, 2=set, 3=clear
- sw_data  in  FLAG_W  software operand
- push  in  1  save flags to stack (call)
- pop  in  1  restore flags from stack (return or trap return)
- trap_ack  in  1  sequencer accepts trap
- flags  out  FLAG_W  registered flag word
- trap_req  out  1  trap pending
- stk_full  out  1  stack full
- stk_empty  out  1  stack empty
- stk_err  out  1  sticky overflow/underflow error

## Operation
- Bit map: Z0 N1 O2 U3 FW4 HWL5 HWH6 DZ7 HWM8 SR9 MV10 MC11 TRAP12. Bits 13 and up are general-purpose.
- ALU update: for each bit i with alu_we[i] set, flags[i] ← alu_flags[i]. If the bit is in STICKY_MASK, flags[i] ← flags[i] | alu_flags[i] instead.
- Software write applies sw_op to the whole word and may clear sticky bits.
- Per-cycle priority: pop restore > trap entry > software write > ALU update. Only the highest-priority source writes the word.
- Stack: LIFO of STACK_DEPTH words.
  - push writes the current registered flags.
  - pop loads the top entry into flags.
  - push and pop in the same cycle: pop wins, push is ignored, stk_err is set.
  - push when full or pop when empty is ignored and sets stk_err.
  - stk_err clears only on reset.
- Trap FSM, states IDLE, REQ, ACTIVE:
  - IDLE→REQ when (flags & TRAP_MASK) ≠ 0 and the TRAP bit is 0.
  - REQ: trap_req=1, held until trap_ack. On ack, the current flags are pushed, TRAP is set, and the state moves to ACTIVE. If the stack is full, the push is dropped, stk_err is set, and the transition still occurs.
  - ACTIVE→IDLE on pop. The restored word normally has TRAP=0.
  - A new trap condition during ACTIVE with TRAP still set is deferred.
  - If software clears TRAP during ACTIVE, the state stays ACTIVE but a new trap may be requested. This permits nesting up to STACK_DEPTH.
  - A pop during REQ restores flags; REQ is re-evaluated against the restored flags and falls back to IDLE if the condition is gone.

## Timing
- Every output is registered, except that stk_full and stk_empty decode directly from the stack pointer.
- Reset values: flags=0, trap_req=0, stk_empty=1, stk_full=0, stk_err=0, FSM=IDLE, stack pointer=0.
- Flag update latency: 1 cycle from input to flags.
- trap_req rises 1 cycle after the triggering flag appears on flags, i.e. 2 cycles after the ALU strobe.
- trap_ack is sampled only in REQ. TRAP appears on flags the cycle after the ack edge.
- Reset asserted mid-operation clears everything immediately; the stack contents become don't-care.

## Configuration
- STATUS_TRAP_EN defined: the trap FSM and handshake exist as described.
- STATUS_TRAP_EN undefined:
  - No FSM; trap_req is tied 0 and trap_ack is ignored.
  - TRAP is writable only by software.
  - push/pop stack behaviour is unchanged.

## Structure
- Shared package status_pkg holds: flag bit-index localparams, the sw_op encoding enum, the trap state enum, and the default STICKY_MASK/TRAP_MASK constants.
- One sub-module, status_stack: a parametrised LIFO with push, pop, full, empty, overflow and underflow.

## Test plan
- Reset, then alu_we=16'h0003 and alu_flags=16'h0002 → next cycle flags=16'h0002 (N=1, Z=0).
- DZ set by ALU, then alu_we bit7=1 with alu_flags bit7=0 → DZ stays 1. Then sw_we with op=clear, data=16'h0080 → DZ=0.
- DZ set → trap_req=1 two cycles after the strobe. trap_ack → TRAP=1, stack holds 16'h0080, trap_req=0. pop → flags=16'h0080, FSM=IDLE; the condition persists, so REQ re-enters.
- STACK_DEPTH=4: 5 pushes → stk_full=1 after the 4th, stk_err=1 after the 5th. 4 pops restore in LIFO order, then stk_empty=1.
- pop and sw_we on the same cycle → flags equals the popped value; the software write is lost.
- Assert reset while in REQ with trap_req=1 → trap_req=0, flags=0, stk_empty=1 immediately. Build without STATUS_TRAP_EN → trap_req is never 1.

Source files
------------

// File: rtl/status_pkg.sv
// -----------------------------------------------------------------------------
// status_pkg
// Shared definitions for the CPU status unit: flag bit positions, the
// software-write opcode encoding, the trap FSM state encoding and the default
// sticky/trap masks.
// -----------------------------------------------------------------------------
package status_pkg;

   // Architectural flag bit positions; bits 13 and up are general-purpose.
   localparam int FLAG_Z    = 0;
   localparam int FLAG_N    = 1;
   localparam int FLAG_O    = 2;
   localparam int FLAG_U    = 3;
   localparam int FLAG_FW   = 4;
   localparam int FLAG_HWL  = 5;
   localparam int FLAG_HWH  = 6;
   localparam int FLAG_DZ   = 7;
   localparam int FLAG_HWM  = 8;
   localparam int FLAG_SR   = 9;
   localparam int FLAG_MV   = 10;
   localparam int FLAG_MC   = 11;
   localparam int FLAG_TRAP = 12;

   localparam int FLAG_MIN_W = 13;

   // O, U, DZ, MV, MC are sticky against ALU updates.
   localparam logic [15:0] DEF_STICKY_MASK = 16'h0C8C;
   // DZ, MV, MC raise a trap.
   localparam logic [15:0] DEF_TRAP_MASK   = 16'h0C80;

   // LSTAT/XSTAT software write operations.
   typedef enum logic [1:0] {
      SW_LOAD  = 2'd0,
      SW_XOR   = 2'd1,
      SW_SET   = 2'd2,
      SW_CLEAR = 2'd3
   } sw_op_e;

   typedef enum logic [1:0] {
      TRAP_IDLE   = 2'd0,
      TRAP_REQ    = 2'd1,
      TRAP_ACTIVE = 2'd2
   } trap_state_e;

endpackage

// File: rtl/status_if.sv
// -----------------------------------------------------------------------------
// status_if
// Bus between the ALU/memory units, the control sequencer and the status unit.
//   master : drives the update strobes, stack requests and trap_ack
//   slave  : the status unit; drives flags, trap_req and stack status
// Signals:
//   alu_we/alu_flags   per-bit ALU update enable and values
//   sw_we/sw_op/sw_data software load/xor/set/clear write
//   push/pop           save/restore stack requests
//   trap_ack           sequencer accepts a pending trap
//   flags              registered flag word
//   trap_req           trap pending
//   stk_full/stk_empty stack occupancy
//   stk_err            sticky stack overflow/underflow/conflict error
// -----------------------------------------------------------------------------
interface status_if #(
   parameter int FLAG_W = 16
);
   import status_pkg::*;

   logic [FLAG_W-1:0] alu_we;
   logic [FLAG_W-1:0] alu_flags;
   logic              sw_we;
   sw_op_e            sw_op;
   logic [FLAG_W-1:0] sw_data;
   logic              push;
   logic              pop;
   logic              trap_ack;
   logic [FLAG_W-1:0] flags;
   logic              trap_req;
   logic              stk_full;
   logic              stk_empty;
   logic              stk_err;

   modport master (
      output alu_we, alu_flags, sw_we, sw_op, sw_data, push, pop, trap_ack,
      input  flags, trap_req, stk_full, stk_empty, stk_err
   );

   modport slave (
      input  alu_we, alu_flags, sw_we, sw_op, sw_data, push, pop, trap_ack,
      output flags, trap_req, stk_full, stk_empty, stk_err
   );

endinterface

// File: rtl/status_stack.sv
// -----------------------------------------------------------------------------
// status_stack
// LIFO of DEPTH words used to save/restore the flag word across calls and
// traps. A simultaneous push and pop performs only the pop.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   i_push       write i_data on top (ignored when full or when popping)
//   i_pop        remove top entry (ignored when empty)
//   i_data       word to push
//   o_top        current top entry (valid when not empty)
//   o_full       pointer == DEPTH
//   o_empty      pointer == 0
//   o_overflow   single-cycle pulse: push refused because full
//   o_underflow  single-cycle pulse: pop refused because empty
// -----------------------------------------------------------------------------
module status_stack #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_top,
   output logic         o_full,
   output logic         o_empty,
   output logic         o_overflow,
   output logic         o_underflow
);

   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_top_idx;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_ptr == PTR_W'(DEPTH));
   assign o_empty   = (r_ptr == '0);

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && !i_pop && !o_full;

   assign o_overflow  = i_push && !i_pop && o_full;
   assign o_underflow = i_pop && o_empty;

   assign w_wr_idx  = IDX_W'(r_ptr);
   assign w_top_idx = IDX_W'(r_ptr - 1'b1);
   assign o_top     = r_mem[w_top_idx];

   // NOTE: the storage array has no reset; only the pointer defines validity,
   // so resetting every entry would add logic without changing behaviour.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (w_do_pop) begin
         r_ptr <= r_ptr - 1'b1;
      end else if (w_do_push) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/status_unit.sv
// -----------------------------------------------------------------------------
// status_unit
// Architectural CPU status register. Holds the flag word and updates it from
// (highest priority first): stack restore on pop, trap entry, software
// LSTAT/XSTAT write, masked ALU update. Sticky bits can only be set by the ALU.
// Current flags can be saved on a LIFO for nested calls and traps.
//
// Optional feature macro: STATUS_TRAP_EN
//   defined   : trap FSM (IDLE/REQ/ACTIVE) with trap_req/trap_ack handshake
//   undefined : no FSM, trap_req tied 0, trap_ack ignored, TRAP bit is
//               writable by software only (ALU writes to it are masked)
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low
//   bus    status_if.slave (ALU/software/stack inputs, flags and status out)
// Parameters:
//   FLAG_W (>=13), STACK_DEPTH (>=1), STICKY_MASK, TRAP_MASK
// -----------------------------------------------------------------------------
module status_unit
   import status_pkg::*;
#(
   parameter int                FLAG_W      = 16,
   parameter int                STACK_DEPTH = 4,
   parameter logic [FLAG_W-1:0] STICKY_MASK = FLAG_W'(DEF_STICKY_MASK),
   parameter logic [FLAG_W-1:0] TRAP_MASK   = FLAG_W'(DEF_TRAP_MASK)
) (
   input  logic     clk,
   input  logic     reset,
   status_if.slave  bus
);

   localparam logic [FLAG_W-1:0] TRAP_BIT = FLAG_W'(1) << FLAG_TRAP;

`ifdef STATUS_TRAP_EN
   localparam logic [FLAG_W-1:0] ALU_WR_MASK = '1;
`else
   localparam logic [FLAG_W-1:0] ALU_WR_MASK = ~TRAP_BIT;
`endif

   logic [FLAG_W-1:0] r_flags;
   logic [FLAG_W-1:0] w_flags_nxt;
   logic [FLAG_W-1:0] w_sw_val;
   logic [FLAG_W-1:0] w_alu_we;
   logic [FLAG_W-1:0] w_alu_val;
   logic [FLAG_W-1:0] w_alu_nxt;
   logic [FLAG_W-1:0] w_stk_top;
   logic              w_stk_full;
   logic              w_stk_empty;
   logic              w_overflow;
   logic              w_underflow;
   logic              w_pop_ok;
   logic              w_trap_entry;
   logic              w_push_req;
   logic              r_stk_err;
   logic              r_trap_req;

   // A pop only restores when there is something to restore; a refused pop
   // leaves the lower-priority sources free to write.
   assign w_pop_ok   = bus.pop && !w_stk_empty;
   assign w_push_req = bus.push || w_trap_entry;

   status_stack #(
      .W     (FLAG_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push_req),
      .i_pop       (bus.pop),
      .i_data      (r_flags),
      .o_top       (w_stk_top),
      .o_full      (w_stk_full),
      .o_empty     (w_stk_empty),
      .o_overflow  (w_overflow),
      .o_underflow (w_underflow)
   );

   // ---------------------------------------------------------------- software
   // NOTE: every combinational output gets a default first so no path through
   // the block can leave it unassigned and infer a latch.
   always_comb begin
      w_sw_val = r_flags;
      unique case (bus.sw_op)
         SW_LOAD:  w_sw_val = bus.sw_data;
         SW_XOR:   w_sw_val = r_flags ^ bus.sw_data;
         SW_SET:   w_sw_val = r_flags | bus.sw_data;
         SW_CLEAR: w_sw_val = r_flags & ~bus.sw_data;
      endcase
   end

   // --------------------------------------------------------------------- ALU
   // Sticky bits OR the new value in; the rest take it directly.
   assign w_alu_we  = bus.alu_we & ALU_WR_MASK;
   assign w_alu_val = (bus.alu_flags & ~STICKY_MASK)
                    | ((r_flags | bus.alu_flags) & STICKY_MASK);
   assign w_alu_nxt = (r_flags & ~w_alu_we) | (w_alu_val & w_alu_we);

   // ---------------------------------------------------------- word priority
   always_comb begin
      w_flags_nxt = w_alu_nxt;
      if (w_pop_ok) begin
         w_flags_nxt = w_stk_top;
      end else if (w_trap_entry) begin
         w_flags_nxt = r_flags | TRAP_BIT;
      end else if (bus.sw_we) begin
         w_flags_nxt = w_sw_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= '0;
      end else begin
         r_flags <= w_flags_nxt;
      end
   end

   // A same-cycle push and pop is a conflict: pop wins, push is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stk_err <= 1'b0;
      end else if (w_overflow || w_underflow || (bus.push && bus.pop)) begin
         r_stk_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- trap FSM
`ifdef STATUS_TRAP_EN
   trap_state_e r_state;
   logic        w_cond_cur;
   logic        w_cond_nxt;

   // A trap condition exists only while TRAP itself is clear; a set TRAP bit
   // defers any new condition until software clears it or the trap returns.
   assign w_cond_cur = (|(r_flags & TRAP_MASK)) && !r_flags[FLAG_TRAP];
   assign w_cond_nxt = (|(w_flags_nxt & TRAP_MASK)) && !w_flags_nxt[FLAG_TRAP];

   assign w_trap_entry = (r_state == TRAP_REQ) && bus.trap_ack && !w_pop_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= TRAP_IDLE;
         r_trap_req <= 1'b0;
      end else begin
         unique case (r_state)
            TRAP_IDLE: begin
               if (w_cond_cur) begin
                  r_state    <= TRAP_REQ;
                  r_trap_req <= 1'b1;
               end
            end
            TRAP_REQ: begin
               if (w_pop_ok) begin
                  // Judge the request against the word being restored so a
                  // stale request is never presented for acknowledge.
                  r_state    <= w_cond_nxt ? TRAP_REQ : TRAP_IDLE;
                  r_trap_req <= w_cond_nxt;
               end else if (bus.trap_ack) begin
                  r_state    <= TRAP_ACTIVE;
                  r_trap_req <= 1'b0;
               end
            end
            TRAP_ACTIVE: begin
               if (w_pop_ok) begin
                  r_state    <= TRAP_IDLE;
                  r_trap_req <= 1'b0;
               end else if (w_cond_cur) begin
                  // Software cleared TRAP inside a handler: allow nesting.
                  r_state    <= TRAP_REQ;
                  r_trap_req <= 1'b1;
               end
            end
            default: begin
               r_state    <= TRAP_IDLE;
               r_trap_req <= 1'b0;
            end
         endcase
      end
   end
`else
   logic w_unused_trap;

   assign w_trap_entry  = 1'b0;
   assign w_unused_trap = bus.trap_ack ^ (|TRAP_MASK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_trap_req <= 1'b0;
      end else begin
         r_trap_req <= 1'b0;
      end
   end
`endif

   // ----------------------------------------------------------------- outputs
   assign bus.flags     = r_flags;
   assign bus.trap_req  = r_trap_req;
   assign bus.stk_full  = w_stk_full;
   assign bus.stk_empty = w_stk_empty;
   assign bus.stk_err   = r_stk_err;

endmodule

// File: tb/tb_status_unit.sv
// -----------------------------------------------------------------------------
// tb_status_unit
// Directed test of status_unit (FLAG_W=16, STACK_DEPTH=4, default masks).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Trap-handshake steps are compiled when STATUS_TRAP_EN is defined; otherwise
// the bench checks that trap_req never asserts and TRAP is software-only.
// -----------------------------------------------------------------------------
module tb_status_unit;
   import status_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   status_if #(.FLAG_W(16)) bus ();

   status_unit #(
      .FLAG_W      (16),
      .STACK_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.alu_we    = '0;
      bus.alu_flags = '0;
      bus.sw_we     = 1'b0;
      bus.sw_op     = SW_LOAD;
      bus.sw_data   = '0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.trap_ack  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      tick();
      reset = 1'b1;
   endtask

   task automatic alu(input logic [15:0] we, input logic [15:0] val);
      bus.alu_we    = we;
      bus.alu_flags = val;
      tick();
      idle_inputs();
   endtask

   task automatic sw(input sw_op_e op, input logic [15:0] data);
      bus.sw_we   = 1'b1;
      bus.sw_op   = op;
      bus.sw_data = data;
      tick();
      idle_inputs();
   endtask

   task automatic stk(input logic do_push, input logic do_pop);
      bus.push = do_push;
      bus.pop  = do_pop;
      tick();
      idle_inputs();
   endtask

   task automatic ack();
      bus.trap_ack = 1'b1;
      tick();
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      check("rst_flags",    bus.flags,     16'h0000);
      check("rst_trap_req", bus.trap_req,  16'h0);
      check("rst_empty",    bus.stk_empty, 16'h1);
      check("rst_full",     bus.stk_full,  16'h0);
      check("rst_err",      bus.stk_err,   16'h0);
      reset = 1'b1;

      // ALU masked update and software ops
      alu(16'h0003, 16'h0002);
      check("alu_n_only",   bus.flags, 16'h0002);
      sw(SW_XOR, 16'h0003);
      check("sw_xor",       bus.flags, 16'h0001);
      sw(SW_SET, 16'h2000);
      check("sw_set",       bus.flags, 16'h2001);
      sw(SW_CLEAR, 16'h0001);
      check("sw_clear",     bus.flags, 16'h2000);
      sw(SW_LOAD, 16'h0000);
      check("sw_load",      bus.flags, 16'h0000);

      // Sticky DZ versus non-sticky Z
      alu(16'h0080, 16'h0080);
      check("dz_set",       bus.flags, 16'h0080);
      alu(16'h0080, 16'h0000);
      check("dz_sticky",    bus.flags, 16'h0080);
      alu(16'h0001, 16'h0001);
      check("z_set",        bus.flags, 16'h0081);
      alu(16'h0001, 16'h0000);
      check("z_clear",      bus.flags, 16'h0080);
      sw(SW_CLEAR, 16'h0080);
      check("dz_sw_clear",  bus.flags, 16'h0000);

`ifdef STATUS_TRAP_EN
      // Trap request / acknowledge / return
      do_reset();
      alu(16'h0080, 16'h0080);
      check("trap_req_1cyc", bus.trap_req, 16'h0);
      tick();
      check("trap_req_2cyc", bus.trap_req, 16'h1);
      tick();
      check("trap_req_held", bus.trap_req, 16'h1);
      ack();
      check("trap_flags",    bus.flags,     16'h1080);
      check("trap_req_ackd", bus.trap_req,  16'h0);
      check("trap_pushed",   bus.stk_empty, 16'h0);
      tick();
      check("trap_deferred", bus.trap_req,  16'h0);
      stk(1'b0, 1'b1);
      check("trap_ret_flags", bus.flags,     16'h0080);
      check("trap_ret_empty", bus.stk_empty, 16'h1);
      check("trap_ret_req",   bus.trap_req,  16'h0);
      tick();
      check("trap_reenter",   bus.trap_req,  16'h1);

      // Pop during REQ restores a clean word and drops the request
      do_reset();
      sw(SW_LOAD, 16'h2000);
      stk(1'b1, 1'b0);
      sw(SW_LOAD, 16'h0400);
      tick();
      check("req_mv",        bus.trap_req, 16'h1);
      stk(1'b0, 1'b1);
      check("req_pop_flags", bus.flags,    16'h2000);
      check("req_pop_drop",  bus.trap_req, 16'h0);
      ack();
      check("idle_ack_ign",  bus.flags,    16'h2000);

      // Software clears TRAP inside a handler: nested trap
      do_reset();
      alu(16'h0800, 16'h0800);
      tick();
      ack();
      check("nest_outer",   bus.flags, 16'h1800);
      sw(SW_CLEAR, 16'h1000);
      check("nest_clr",     bus.trap_req, 16'h0);
      tick();
      check("nest_req",     bus.trap_req, 16'h1);
      ack();
      check("nest_inner",   bus.flags, 16'h1800);
      stk(1'b0, 1'b1);
      check("nest_pop1",    bus.flags, 16'h0800);
      check("nest_pop1_ne", bus.stk_empty, 16'h0);
`else
      // Without the trap feature: no request, ack ignored, ALU cannot touch TRAP
      do_reset();
      alu(16'h0080, 16'h0080);
      tick();
      check("notrap_req_a", bus.trap_req, 16'h0);
      tick();
      check("notrap_req_b", bus.trap_req, 16'h0);
      ack();
      check("notrap_ack",   bus.flags,     16'h0080);
      check("notrap_empty", bus.stk_empty, 16'h1);
      alu(16'h1000, 16'h1000);
      check("notrap_alu_trap", bus.flags, 16'h0080);
      sw(SW_SET, 16'h1000);
      check("notrap_sw_trap",  bus.flags, 16'h1080);
      check("notrap_req_c",    bus.trap_req, 16'h0);
`endif

      // Stack depth 4: overflow on the 5th push, LIFO restore
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         sw(SW_LOAD, 16'h2000 + 16'(i));
         stk(1'b1, 1'b0);
         if (i == 3) check("stk_full_3", bus.stk_full, 16'h0);
         if (i == 4) begin
            check("stk_full_4", bus.stk_full, 16'h1);
            check("stk_err_4",  bus.stk_err,  16'h0);
         end
         if (i == 5) begin
            check("stk_full_5", bus.stk_full, 16'h1);
            check("stk_err_5",  bus.stk_err,  16'h1);
         end
      end
      for (int i = 4; i >= 1; i--) begin
         stk(1'b0, 1'b1);
         check($sformatf("stk_pop_%0d", i), bus.flags, 16'h2000 + 16'(i));
      end
      check("stk_empty_end", bus.stk_empty, 16'h1);
      check("stk_full_end",  bus.stk_full,  16'h0);
      check("stk_err_keep",  bus.stk_err,   16'h1);

      // Pop beats software write; push+pop conflict
      do_reset();
      sw(SW_LOAD, 16'h4000);
      stk(1'b1, 1'b0);
      sw(SW_LOAD, 16'h0001);
      bus.sw_we   = 1'b1;
      bus.sw_op   = SW_LOAD;
      bus.sw_data = 16'hFFFF;
      bus.pop     = 1'b1;
      tick();
      idle_inputs();
      check("pop_vs_sw",      bus.flags,     16'h4000);
      check("pop_vs_sw_err",  bus.stk_err,   16'h0);
      check("pop_vs_sw_empt", bus.stk_empty, 16'h1);
      stk(1'b1, 1'b0);
      sw(SW_LOAD, 16'h0002);
      stk(1'b1, 1'b1);
      check("pushpop_flags", bus.flags,     16'h4000);
      check("pushpop_err",   bus.stk_err,   16'h1);
      check("pushpop_empty", bus.stk_empty, 16'h1);

      // Asynchronous reset in the middle of operation
      do_reset();
      sw(SW_LOAD, 16'h2004);
      stk(1'b1, 1'b0);
`ifdef STATUS_TRAP_EN
      alu(16'h0080, 16'h0080);
      tick();
      check("pre_rst_req", bus.trap_req, 16'h1);
`endif
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_flags", bus.flags,     16'h0000);
      check("async_rst_req",   bus.trap_req,  16'h0);
      check("async_rst_empty", bus.stk_empty, 16'h1);
      check("async_rst_err",   bus.stk_err,   16'h0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_flags", bus.flags, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
